det2_stream_engine: RTL and testbench
=====================================

DET2_STREAM_ENGINE -- requirements
Module: det2_stream_engine

Interface
REQ-001 Parameter W, 4, operand width in bits (2..16).
REQ-002 Parameter DEPTH, 16, number of program words processed per run (2..256).
REQ-003 Parameter AW, clog2(DEPTH), program address width.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  pulse; begins a run when idle.
REQ-007 signed_mode  input  1  1 = operands two's complement, 0 = unsigned.
REQ-008 rom_en  output  1  read strobe to external program memory.
REQ-009 rom_addr  output  AW  word address; valid while rom_en=1.
REQ-010 rom_data  input  4W  read data, valid the cycle after rom_en=1.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  2W+1  signed a*d - b*c.
REQ-014 result_idx  output  AW  program address the result came from.
REQ-015 busy  output  1  run in progress.
REQ-016 done  output  1  one-cycle pulse after last result accepted.

Function
REQ-017 rom_data fields: a=[W-1:0], c=[2W-1:W], d=[3W-1:2W], b=[4W-1:3W].
REQ-018 FSM states IDLE, FETCH, LOAD, MUL_AD, MUL_BC, OUTPUT; reset state IDLE.
REQ-019 IDLE: start=1 -> FETCH, pc=0, signed_mode captured into mode register for the whole run; busy=1 from next cycle.
REQ-020 FETCH: rom_en=1, rom_addr=pc; -> LOAD.
REQ-021 LOAD: capture a,b,c,d from rom_data; -> MUL_AD.
REQ-022 MUL_AD: single shared multiplier computes a*d into product register; -> MUL_BC.
REQ-023 MUL_BC: same multiplier computes b*c; result register = ad - bc; result_idx=pc; -> OUTPUT.
REQ-024 Operand extension: zero-extend when mode=0, sign-extend when mode=1; result always 2W+1-bit two's complement, never overflows.
REQ-025 OUTPUT: out_valid=1; result, result_idx stable until out_valid&out_ready.
REQ-026 On handshake with pc<DEPTH-1: pc+1, -> FETCH; with pc=DEPTH-1: -> IDLE, done=1 one cycle, busy=0.
REQ-027 Minimum latency: start in cycle k -> out_valid in cycle k+5; per-word throughput 5 cycles with out_ready held 1.
REQ-028 start while busy is ignored; signed_mode changes mid-run have no effect.
REQ-029 rom_addr never exceeds DEPTH-1; rom_en=0 outside FETCH.

Reset
REQ-030 reset forces IDLE, pc=0, out_valid=0, busy=0, done=0, rom_en=0, result=0, result_idx=0, mode=0.
REQ-031 reset mid-run aborts immediately; no further rom_en or out_valid until a new start.
REQ-032 reset has priority over start in the same cycle.

Structure
REQ-033 Package det2_pkg holds the FSM state enum and the field offset constants of REQ-017.
REQ-034 Sub-module det_mul: combinational (W+1)x(W+1) signed multiplier instantiated once and time-shared via operand mux.

Verification
REQ-035 W=4 unsigned, word a=3,c=2,d=5,b=4 -> result=7, result_idx=0, out_valid at k+5.
REQ-036 W=4 signed, a=0xE(-2),d=3,b=1,c=2 -> result=-8; same word unsigned -> 40.
REQ-037 Extremes W=4 unsigned: a=d=15,b=c=0 -> 225; a=d=0,b=c=15 -> -225; signed a=d=-8,b=c=0 -> 64.
REQ-038 out_ready low 3 cycles in OUTPUT -> out_valid, result, result_idx held, rom_en stays 0.
REQ-039 DEPTH=4 run -> exactly 4 results with idx 0..3, done pulses once, busy falls same cycle, rom_addr never 4.
REQ-040 reset asserted in MUL_BC -> next cycle out_valid=0, busy=0; new start restarts at rom_addr=0.

Source files
------------

// File: rtl/det2_pkg.sv
// Shared types for the 2x2 determinant stream engine.
// FSM encoding and rom_data field positions (in units of W bits).
package det2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      MUL_AD,
      MUL_BC,
      OUTPUT
   } det2_state_t;

   localparam int A_FLD = 0;
   localparam int C_FLD = 1;
   localparam int D_FLD = 2;
   localparam int B_FLD = 3;

endpackage

// File: rtl/det_mul.sv
// Combinational signed multiplier, shared between the a*d and b*c steps.
// Operands arrive already zero- or sign-extended to W+1 bits.
module det_mul #(
   parameter int W = 4
) (
   input  logic signed [W:0]     x,
   input  logic signed [W:0]     y,
   output logic signed [2*W+1:0] p
);

   assign p = x * y;

endmodule

// File: rtl/det2_stream_engine.sv
// Streams 2x2 matrices from program memory and emits a*d - b*c per word.
// One multiplier is time-shared across the MUL_AD and MUL_BC states.
module det2_stream_engine
   import det2_pkg::*;
#(
   parameter int W     = 4,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          signed_mode,
   output logic          rom_en,
   output logic [AW-1:0] rom_addr,
   input  logic [4*W-1:0] rom_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2*W:0]  result,
   output logic [AW-1:0] result_idx,
   output logic          busy,
   output logic          done
);

   localparam int PW = 2 * W + 2;

   det2_state_t           state;
   logic [AW-1:0]         pc;
   logic                  mode;
   logic [W-1:0]          op_a, op_b, op_c, op_d;
   logic signed [PW-1:0]  prod;
   logic signed [W:0]     mul_x, mul_y;
   logic signed [PW-1:0]  mul_p;
   logic signed [PW-1:0]  diff;
   logic                  last;

   // Extension bit is the operand MSB only when the run is signed.
   always_comb begin
      mul_x = {mode & op_b[W-1], op_b};
      mul_y = {mode & op_c[W-1], op_c};
      if (state == MUL_AD) begin
         mul_x = {mode & op_a[W-1], op_a};
         mul_y = {mode & op_d[W-1], op_d};
      end
   end

   det_mul #(.W(W)) u_mul (
      .x (mul_x),
      .y (mul_y),
      .p (mul_p)
   );

   assign diff     = prod - mul_p;
   assign last     = (pc == AW'(DEPTH - 1));
   assign rom_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= '0;
         mode       <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         op_c       <= '0;
         op_d       <= '0;
         prod       <= '0;
         rom_en     <= 1'b0;
         out_valid  <= 1'b0;
         result     <= '0;
         result_idx <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= FETCH;
                  pc     <= '0;
                  mode   <= signed_mode;
                  busy   <= 1'b1;
                  rom_en <= 1'b1;
               end
            end
            FETCH: begin
               rom_en <= 1'b0;
               state  <= LOAD;
            end
            LOAD: begin
               op_a  <= rom_data[A_FLD*W +: W];
               op_b  <= rom_data[B_FLD*W +: W];
               op_c  <= rom_data[C_FLD*W +: W];
               op_d  <= rom_data[D_FLD*W +: W];
               state <= MUL_AD;
            end
            MUL_AD: begin
               prod  <= mul_p;
               state <= MUL_BC;
            end
            MUL_BC: begin
               result     <= diff[2*W:0];
               result_idx <= pc;
               out_valid  <= 1'b1;
               state      <= OUTPUT;
            end
            OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (last) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     pc     <= pc + AW'(1);
                     rom_en <= 1'b1;
                     state  <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_det2_stream_engine.sv
// Directed bench for det2_stream_engine with W=4, DEPTH=4.
// Program memory model answers one cycle after rom_en.
module tb_det2_stream_engine;

   localparam int W     = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            signed_mode;
   logic            rom_en;
   logic [AW-1:0]   rom_addr;
   logic [4*W-1:0]  rom_data;
   logic            out_valid;
   logic            out_ready;
   logic [2*W:0]    result;
   logic [AW-1:0]   result_idx;
   logic            busy;
   logic            done;

   logic [4*W-1:0]  rom [DEPTH];
   int              n_chk  = 0;
   int              n_pass = 0;
   int              done_cnt = 0;

   always #5 clk = ~clk;

   det2_stream_engine #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .signed_mode(signed_mode),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .result_idx (result_idx),
      .busy       (busy),
      .done       (done)
   );

   always @(posedge clk)
      if (rom_en) rom_data <= rom[rom_addr];

   always @(negedge clk)
      if (done) done_cnt++;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic run(input logic m, input int e0, input int e1,
                      input int e2, input int e3, input bit stall);
      int ex[4];
      int n;
      int d0;
      ex = '{e0, e1, e2, e3};
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      signed_mode = m;
      @(negedge clk);
      start = 1'b0;
      signed_mode = ~m;
      n = 1;
      check("fetch_en", rom_en, 1);
      check("fetch_addr", rom_addr, 0);
      check("busy_run", busy, 1);
      for (int i = 0; i < DEPTH; i++) begin
         while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("latency", n, 5);
         check("result", result, ex[i]);
         check("idx", result_idx, i);
         if (stall && i == 1) begin
            out_ready = 1'b0;
            start = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check("hold_v", out_valid, 1);
               check("hold_r", result, ex[i]);
               check("hold_i", result_idx, i);
               check("hold_en", rom_en, 0);
            end
            start = 1'b0;
            out_ready = 1'b1;
         end
         @(negedge clk);
         n = 1;
         if (i < DEPTH - 1) begin
            check("next_en", rom_en, 1);
            check("next_addr", rom_addr, i + 1);
         end
      end
      check("done", done, 1);
      check("busy_fall", busy, 0);
      @(negedge clk);
      #1;
      check("done_once", done_cnt - d0, 1);
      check("done_low", done, 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      signed_mode = 1'b0;
      out_ready = 1'b1;
      rom_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_en", rom_en, 0);
      check("rst_result", result, 0);
      check("rst_idx", result_idx, 0);
      reset = 1'b0;

      // {b,d,c,a}
      rom[0] = 16'h4523;
      rom[1] = 16'h132E;
      rom[2] = 16'h0F0F;
      rom[3] = 16'hF0F0;
      run(1'b0, 7, 40, 225, 287, 1'b1);

      rom[0] = 16'h0808;
      run(1'b1, 64, 504, 1, 511, 1'b0);

      // abort a run while in MUL_BC
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_en", rom_en, 0);
      start = 1'b1;
      @(negedge clk);
      check("rst_prio", busy, 0);
      reset = 1'b0;
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("idle_valid", out_valid, 0);
      check("idle_en", rom_en, 0);

      run(1'b0, 64, 40, 225, 287, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
